// File: rtl/tiles_pkg.sv
// Shared constants, FSM state encoding and lane geometry helper for the
// falling-tile game datapath.
package tiles_pkg;

    localparam int         TILE_W      = 40;
    localparam int         TILE_H      = 30;
    localparam int         SCREEN_W    = 160;
    localparam int         SCREEN_H    = 120;
    localparam logic [2:0] TILE_COLOUR = 3'b000;
    localparam logic [2:0] BG_COLOUR   = 3'b111;
    localparam logic [7:0] LFSR_SEED   = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_WAIT   = 3'd2,
        S_ERASE  = 3'd3,
        S_UPDATE = 3'd4,
        S_DRAW   = 3'd5,
        S_OVER   = 3'd6
    } state_t;

    // Left pixel column of a lane; four lanes of at most 40 px fit in 8 bits.
    function automatic logic [7:0] lane_x(input logic [1:0] lane, input logic [7:0] tile_w);
        return {6'd0, lane} * tile_w;
    endfunction

endpackage

// File: rtl/lane_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) used to pick respawn lanes.
module lane_lfsr
    import tiles_pkg::*;
#(
    parameter logic [7:0] SEED = LFSR_SEED
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       advance,
    output logic [7:0] lfsr
);

    logic [7:0] lfsr_r;
    logic       feedback_s;

    // Feedback taps for bits 8,6,5,4; a non-zero seed never reaches all-zero.
    always_comb begin
        feedback_s = lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3];
    end

    // Shift register with asynchronous return to the seed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_r <= SEED;
        end else if (advance) begin
            lfsr_r <= {lfsr_r[6:0], feedback_s};
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign lfsr = lfsr_r;

endmodule

// File: rtl/tile_frame_scheduler.sv
// Frame scheduler for the falling-tile game: moves four tiles once per frame and
// sequences their erase/draw rectangles through the shared fill datapath.
module tile_frame_scheduler #(
    parameter int         TILE_W      = 40,
    parameter int         TILE_H      = 30,
    parameter int         SCREEN_H    = 120,
    parameter int         HIT_Y       = 60,
    parameter logic [2:0] TILE_COLOUR = 3'b000,
    parameter logic [2:0] BG_COLOUR   = 3'b111
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       frame_tick,
    input  logic [1:0] speed,
    input  logic [3:0] keys,
    output logic       rect_req,
    output logic [7:0] rect_x,
    output logic [6:0] rect_y,
    output logic [2:0] rect_colour,
    input  logic       rect_ack,
    output logic       busy,
    output logic       overrun,
    output logic [7:0] score,
    output logic       game_over
);
    import tiles_pkg::*;

    localparam logic [7:0] TILE_W_L = 8'(TILE_W);
    localparam logic [6:0] TILE_H_L = 7'(TILE_H);
    localparam logic [6:0] Y_LIMIT  = 7'(SCREEN_H - TILE_H);
    localparam logic [6:0] HIT_Y_L  = 7'(HIT_Y);

    state_t     state_r;
    logic [1:0] idx_r;
    logic [6:0] tile_y_r    [4];
    logic [1:0] tile_lane_r [4];
    logic [3:0] hit_pend_r;
    logic       rect_req_r;
    logic [7:0] rect_x_r;
    logic [6:0] rect_y_r;
    logic [2:0] rect_colour_r;
    logic       busy_r;
    logic       overrun_r;
    logic [7:0] score_r;
    logic       game_over_r;

    logic [7:0] lfsr_s;
    logic       lfsr_unused_s;
    logic [1:0] cur_lane_s;
    logic [6:0] cur_y_s;
    logic       hit_s;
    logic [6:0] new_y_s;
    logic [1:0] new_lane_s;
    logic       over_s;
    logic [7:0] score_next_s;
    logic [6:0] init_y_s;
    logic [3:0] pend_set_s;
    logic [3:0] pend_clr_s;
    logic [3:0] hit_pend_next_s;

    lane_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .resetn  (resetn),
        .advance (1'b1),
        .lfsr    (lfsr_s)
    );

    // Only the two low LFSR bits select a lane.
    assign lfsr_unused_s = ^lfsr_s[7:2];

    // Move / hit arithmetic for the tile currently selected by idx_r.
    always_comb begin
        cur_lane_s = tile_lane_r[idx_r];
        cur_y_s    = tile_y_r[idx_r];
        hit_s      = hit_pend_r[cur_lane_s] && (cur_y_s >= HIT_Y_L);
        if (hit_s) begin
            new_y_s    = 7'd0;
            new_lane_s = lfsr_s[1:0];
        end else begin
            new_y_s    = cur_y_s + {5'd0, speed} + 7'd1;
            new_lane_s = cur_lane_s;
        end
        over_s       = (new_y_s > Y_LIMIT);
        score_next_s = (score_r == 8'hFF) ? score_r : (score_r + 8'd1);
        init_y_s     = TILE_H_L * {5'd0, idx_r};
    end

    // Key latching: keys accumulate while a game runs; clears win over sets.
    always_comb begin
        pend_set_s = 4'd0;
        pend_clr_s = 4'd0;
        if ((state_r != S_IDLE) && (state_r != S_OVER)) begin
            pend_set_s = keys;
        end else begin
            pend_set_s = 4'd0;
        end
        case (state_r)
            S_INIT: pend_clr_s = 4'hF;
            S_UPDATE: begin
                if (hit_s) begin
                    pend_clr_s = 4'd1 << cur_lane_s;
                end else begin
                    pend_clr_s = 4'd0;
                end
            end
            S_DRAW: begin
                if (rect_req_r && rect_ack && (idx_r == 2'd3)) begin
                    pend_clr_s = 4'hF;
                end else begin
                    pend_clr_s = 4'd0;
                end
            end
            default: pend_clr_s = 4'd0;
        endcase
        hit_pend_next_s = (hit_pend_r | pend_set_s) & ~pend_clr_s;
    end

    // Frame sequencer with registered rectangle, status and score outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r       <= S_IDLE;
            idx_r         <= 2'd0;
            hit_pend_r    <= 4'd0;
            rect_req_r    <= 1'b0;
            rect_x_r      <= 8'd0;
            rect_y_r      <= 7'd0;
            rect_colour_r <= 3'd0;
            busy_r        <= 1'b0;
            overrun_r     <= 1'b0;
            score_r       <= 8'd0;
            game_over_r   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                tile_y_r[i]    <= 7'd0;
                tile_lane_r[i] <= 2'd0;
            end
        end else begin
            overrun_r  <= 1'b0;
            hit_pend_r <= hit_pend_next_s;
            case (state_r)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        state_r <= S_INIT;
                        idx_r   <= 2'd0;
                    end
                end
                // One tile per cycle so each gets a fresh LFSR lane.
                S_INIT: begin
                    tile_y_r[idx_r]    <= init_y_s;
                    tile_lane_r[idx_r] <= lfsr_s[1:0];
                    score_r            <= 8'd0;
                    game_over_r        <= 1'b0;
                    if (idx_r == 2'd3) begin
                        idx_r   <= 2'd0;
                        state_r <= S_WAIT;
                    end else begin
                        idx_r <= idx_r + 2'd1;
                    end
                end
                S_WAIT: begin
                    if (frame_tick) begin
                        idx_r   <= 2'd0;
                        busy_r  <= 1'b1;
                        state_r <= S_ERASE;
                    end
                end
                S_ERASE: begin
                    overrun_r <= frame_tick;
                    if (!rect_req_r) begin
                        rect_req_r    <= 1'b1;
                        rect_x_r      <= lane_x(cur_lane_s, TILE_W_L);
                        rect_y_r      <= cur_y_s;
                        rect_colour_r <= BG_COLOUR;
                    end else if (rect_ack) begin
                        rect_req_r <= 1'b0;
                        state_r    <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    overrun_r          <= frame_tick;
                    tile_y_r[idx_r]    <= new_y_s;
                    tile_lane_r[idx_r] <= new_lane_s;
                    if (hit_s) begin
                        score_r <= score_next_s;
                    end
                    if (over_s) begin
                        game_over_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= S_OVER;
                    end else begin
                        state_r <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    overrun_r <= frame_tick;
                    if (!rect_req_r) begin
                        rect_req_r    <= 1'b1;
                        rect_x_r      <= lane_x(cur_lane_s, TILE_W_L);
                        rect_y_r      <= cur_y_s;
                        rect_colour_r <= TILE_COLOUR;
                    end else if (rect_ack) begin
                        rect_req_r <= 1'b0;
                        if (idx_r == 2'd3) begin
                            busy_r  <= 1'b0;
                            state_r <= S_WAIT;
                        end else begin
                            idx_r   <= idx_r + 2'd1;
                            state_r <= S_ERASE;
                        end
                    end
                end
                default: begin
                    rect_req_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= S_IDLE;
                end
            endcase
        end
    end

    assign rect_req    = rect_req_r;
    assign rect_x      = rect_x_r;
    assign rect_y      = rect_y_r;
    assign rect_colour = rect_colour_r;
    assign busy        = busy_r;
    assign overrun     = overrun_r;
    assign score       = score_r;
    assign game_over   = game_over_r;

endmodule

// File: tb/tb_tile_frame_scheduler.sv
// Self-checking bench for tile_frame_scheduler: a per-tile game model predicts
// every rectangle, score and game-over outcome.
module tb_tile_frame_scheduler;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       frame_tick = 1'b0;
    logic [1:0] speed = 2'd0;
    logic [3:0] keys = 4'd0;
    logic       rect_ack = 1'b0;
    logic       rect_req;
    logic [7:0] rect_x;
    logic [6:0] rect_y;
    logic [2:0] rect_colour;
    logic       busy;
    logic       overrun;
    logic [7:0] score;
    logic       game_over;

    int tests_run = 0;
    int tests_failed = 0;

    // Game model: tile positions, lanes, latched keys, score and game state.
    logic [7:0] m_lfsr;
    int         m_y [4];
    int         m_lane [4];
    int         m_score;
    bit         m_over;
    logic [3:0] m_pend;

    always #10 clk = ~clk;

    // Reference pseudo-random sequence: x^8+x^6+x^5+x^4+1 from seed A5 each cycle.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) m_lfsr <= 8'hA5;
        else         m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    tile_frame_scheduler dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .frame_tick  (frame_tick),
        .speed       (speed),
        .keys        (keys),
        .rect_req    (rect_req),
        .rect_x      (rect_x),
        .rect_y      (rect_y),
        .rect_colour (rect_colour),
        .rect_ack    (rect_ack),
        .busy        (busy),
        .overrun     (overrun),
        .score       (score),
        .game_over   (game_over)
    );

    task automatic do_start(input bit with_tick);
        @(negedge clk); start = 1'b1; frame_tick = with_tick;
        @(negedge clk); start = 1'b0; frame_tick = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_lane[i] = int'(m_lfsr[1:0]);
            m_y[i]    = 30 * i;
            if (i < 3) @(negedge clk);
        end
        m_score = 0; m_over = 1'b0; m_pend = 4'd0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_keys(input logic [3:0] k);
        @(negedge clk); keys = k;
        @(negedge clk); keys = 4'd0;
        m_pend = m_pend | k;
    endtask

    // One frame pass: tick, auto-ack every rectangle, compare each against the model.
    task automatic run_pass(input logic [3:0] held, input int ack_dly, input int inj_req);
        int idx, wait_cnt, nreq, ovr, cyc, lane, exp_x, exp_y, exp_c;
        bit draw_ph, in_req, acked, done, over_pend, extra_req, hit;
        idx = 0; wait_cnt = 0; nreq = 0; ovr = 0; cyc = 0;
        exp_x = 0; exp_y = 0; exp_c = 0;
        draw_ph = 0; in_req = 0; acked = 0; done = 0; over_pend = 0; extra_req = 0;
        keys = held;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL busy_rise: busy=%b expected 1", busy); end
        while (!done && cyc < 400) begin
            @(negedge clk); cyc++;
            if (overrun === 1'b1) ovr++;
            frame_tick = 1'b0; start = 1'b0;
            if (over_pend) begin
                tests_run++;
                if (busy !== 1'b0 || game_over !== 1'b1 || rect_req !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL over_entry: busy=%b game_over=%b req=%b expected 0 1 0", busy, game_over, rect_req);
                end
                done = 1;
            end else if (acked) begin
                rect_ack = 1'b0; acked = 0; in_req = 0;
                tests_run++;
                if (rect_req !== 1'b0) begin tests_failed++; $display("FAIL req_fall: req=%b expected 0", rect_req); end
                if (!draw_ph) begin
                    lane = m_lane[idx];
                    hit = (m_pend[lane] | held[lane]) && (m_y[idx] >= 60);
                    if (hit) begin
                        m_y[idx] = 0; m_lane[idx] = int'(m_lfsr[1:0]);
                        if (m_score < 255) m_score++;
                        m_pend[lane] = 1'b0;
                    end else begin
                        m_y[idx] = m_y[idx] + int'(speed) + 1;
                    end
                    if (m_y[idx] > 90) begin m_over = 1'b1; over_pend = 1; end
                    else draw_ph = 1;
                end else if (idx == 3) begin
                    m_pend = 4'd0;
                    tests_run++;
                    if (busy !== 1'b0) begin tests_failed++; $display("FAIL busy_fall: busy=%b expected 0", busy); end
                    done = 1;
                end else begin
                    idx++; draw_ph = 0;
                end
            end else if (in_req) begin
                wait_cnt++;
            end else if (rect_req === 1'b1) begin
                in_req = 1; wait_cnt = 0; nreq++;
                exp_x = m_lane[idx] * 40; exp_y = m_y[idx]; exp_c = draw_ph ? 0 : 7;
                tests_run++;
                if (rect_x !== exp_x[7:0] || rect_y !== exp_y[6:0] || rect_colour !== exp_c[2:0]) begin
                    tests_failed++;
                    $display("FAIL rect_%0d: got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                             nreq, rect_x, rect_y, rect_colour, exp_x, exp_y, exp_c);
                end
                if (nreq == inj_req) begin frame_tick = 1'b1; start = 1'b1; end
            end
            if (in_req && !acked && wait_cnt >= ack_dly) begin
                tests_run++;
                if (rect_req !== 1'b1 || rect_x !== exp_x[7:0] || rect_y !== exp_y[6:0] || rect_colour !== exp_c[2:0]) begin
                    tests_failed++;
                    $display("FAIL rect_stable: got req=%b x=%0d y=%0d expected 1 %0d %0d", rect_req, rect_x, rect_y, exp_x, exp_y);
                end
                rect_ack = 1'b1; acked = 1;
            end
        end
        rect_ack = 1'b0;
        if (!done) begin tests_run++; tests_failed++; $display("FAIL pass_timeout: %0d requests seen, pass never ended", nreq); end
        repeat (4) begin
            @(negedge clk);
            if (overrun === 1'b1) ovr++;
            if (rect_req !== 1'b0 || busy !== 1'b0) extra_req = 1;
        end
        keys = 4'd0;
        if (!m_over) m_pend = m_pend | held;
        tests_run++;
        if (extra_req) begin tests_failed++; $display("FAIL idle_after_pass: activity after pass, expected none"); end
        tests_run++;
        if (ovr != ((inj_req > 0) ? 1 : 0)) begin
            tests_failed++; $display("FAIL overrun_count: got %0d expected %0d", ovr, (inj_req > 0) ? 1 : 0);
        end
        tests_run++;
        if (score !== 8'(m_score) || game_over !== m_over) begin
            tests_failed++; $display("FAIL pass_status: score=%0d over=%b expected %0d %b", score, game_over, m_score, m_over);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        tests_run++;
        if (rect_req !== 1'b0 || rect_x !== 8'd0 || rect_y !== 7'd0 || rect_colour !== 3'd0 ||
            busy !== 1'b0 || overrun !== 1'b0 || score !== 8'd0 || game_over !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s: req=%b x=%0d y=%0d c=%0d busy=%b ovr=%b score=%0d go=%b expected all 0",
                     name, rect_req, rect_x, rect_y, rect_colour, busy, overrun, score, game_over);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_state");
        resetn = 1'b1;
        @(negedge clk);
        check_idle_outputs("after_release");
    endtask

    task automatic test_over_tick();
        bit bad;
        bad = 0;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        repeat (6) begin
            if (overrun !== 1'b0 || busy !== 1'b0 || rect_req !== 1'b0) bad = 1;
            @(negedge clk);
        end
        tests_run++;
        if (bad || game_over !== 1'b1) begin
            tests_failed++; $display("FAIL over_tick: activity or game_over=%b in over state, expected none and 1", game_over);
        end
    endtask

    task automatic test_first_pass();
        speed = 2'd0;
        do_start(1'b0);
        run_pass(4'd0, 3, 0);
        tests_run++;
        if (game_over !== 1'b1) begin tests_failed++; $display("FAIL first_pass_over: game_over=%b expected 1", game_over); end
        test_over_tick();
    endtask

    task automatic test_key_hit();
        do_start(1'b0);
        tests_run++;
        if (game_over !== 1'b0 || score !== 8'd0) begin
            tests_failed++; $display("FAIL restart: game_over=%b score=%0d expected 0 0", game_over, score);
        end
        run_pass(4'd1 << m_lane[3], 1, 0);
        tests_run++;
        if (game_over !== 1'b0) begin tests_failed++; $display("FAIL key_hit_alive: game_over=%b expected 0", game_over); end
    endtask

    task automatic test_early_key();
        pulse_keys(4'd1 << m_lane[0]);
        run_pass(4'd0, 2, 0);
        run_pass(4'd0, 1, 0);
    endtask

    task automatic test_overrun();
        run_pass(4'd0, 2, 3);
    endtask

    task automatic test_reset_mid();
        int n;
        bit seen;
        n = 0; seen = 0;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk); n++;
            if (rect_req === 1'b1) seen = 1;
        end
        tests_run++;
        if (!seen) begin tests_failed++; $display("FAIL mid_req_wait: req never rose, expected 1"); end
        #2 resetn = 1'b0;
        #1 check_idle_outputs("async_reset");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        speed = 2'($urandom_range(0, 2));
        do_start(1'b1);
        tests_run++;
        if (busy !== 1'b0 || rect_req !== 1'b0 || score !== 8'd0 || game_over !== 1'b0) begin
            tests_failed++; $display("FAIL start_priority: busy=%b req=%b score=%0d go=%b expected 0 0 0 0", busy, rect_req, score, game_over);
        end
        run_pass(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 0);
    endtask

    task automatic test_saturation();
        int passes;
        passes = 0;
        speed = 2'd3;
        if (m_over) do_start(1'b0);
        while (m_score < 255 && !m_over && passes < 1400) begin
            run_pass(4'hF, 0, 0);
            passes++;
        end
        repeat (4) run_pass(4'hF, 0, 0);
        tests_run++;
        if (score !== 8'd255) begin tests_failed++; $display("FAIL score_saturate: score=%0d expected 255", score); end
        passes = 0;
        while (!m_over && passes < 40) begin
            run_pass(4'd0, 0, 0);
            passes++;
        end
        tests_run++;
        if (game_over !== 1'b1 || score !== 8'd255) begin
            tests_failed++; $display("FAIL sat_game_over: game_over=%b score=%0d expected 1 255", game_over, score);
        end
        test_over_tick();
        do_start(1'b0);
        tests_run++;
        if (game_over !== 1'b0 || score !== 8'd0) begin
            tests_failed++; $display("FAIL restart_from_over: game_over=%b score=%0d expected 0 0", game_over, score);
        end
    endtask

    initial begin
        test_reset();
        test_first_pass();
        test_key_hit();
        test_early_key();
        test_overrun();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
